alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 140 ++++++++++++++
 tb/tb_alu_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one external ALU: arbitrate, issue, wait, return result.
// ALU_ARB_RR_EN selects round-robin arbitration; default build is fixed priority (requester 0 wins).
module alu_arbiter #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0] state, state_nxt;
  logic       owner, owner_nxt;
  logic       grant0, grant1;
  logic       accept;
  logic       capture;
  logic       busy_nxt, start_nxt, rsp0_valid_nxt, rsp1_valid_nxt;

`ifdef ALU_ARB_RR_EN
  // last_grant=1 after reset so requester 0 is favoured first
  logic last_grant;

  always_comb begin
    grant0 = req0_valid & (~req1_valid | last_grant);
    grant1 = req1_valid & (~req0_valid | ~last_grant);
  end

  always_ff @(posedge clk) begin
    if (rst)         last_grant <= 1'b1;
    else if (accept) last_grant <= grant1;
  end
`else
  always_comb begin
    grant0 = req0_valid;
    grant1 = req1_valid & ~req0_valid;
  end
`endif

  // Ready is offered only in IDLE and never while reset is being applied
  assign req0_ready = (state == IDLE) & ~rst & grant0;
  assign req1_ready = (state == IDLE) & ~rst & grant1;
  assign accept     = req0_ready | req1_ready;

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = ISSUE;
          owner_nxt = grant1;
        end
      end
      ISSUE: begin
        capture   = alu_done;
        state_nxt = alu_done ? RESP : WAIT;
      end
      WAIT: begin
        if (alu_done) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (owner ? rsp1_ready : rsp0_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt       = (state_nxt != IDLE);
    start_nxt      = (state_nxt == ISSUE);
    rsp0_valid_nxt = (state_nxt == RESP) & ~owner_nxt;
    rsp1_valid_nxt = (state_nxt == RESP) & owner_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      busy       <= 1'b0;
      alu_start  <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      busy       <= busy_nxt;
      alu_start  <= start_nxt;
      rsp0_valid <= rsp0_valid_nxt;
      rsp1_valid <= rsp1_valid_nxt;
    end
  end

  // Operand latch on acceptance; result capture into the owner's slot only
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      rsp0_result <= '0;
      rsp1_result <= '0;
    end else begin
      if (accept) begin
        alu_op <= grant1 ? req1_op : req0_op;
        alu_a  <= grant1 ? req1_a  : req0_a;
        alu_b  <= grant1 ? req1_b  : req0_b;
      end
      if (capture && !owner) rsp0_result <= alu_result;
      if (capture && owner)  rsp1_result <= alu_result;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a response scoreboard and a stand-in ALU.
module tb_alu_arbiter;
  localparam int unsigned W   = 128;
  localparam int unsigned OPW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0_valid, req0_ready, req1_valid, req1_ready;
  logic [OPW-1:0] req0_op, req1_op, alu_op;
  logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
  logic           rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [W-1:0]   rsp0_result, rsp1_result;
  logic [W-1:0]   alu_a, alu_b, alu_result;
  logic           alu_start, alu_done, busy;

  logic           auto_alu, done_man;
  logic [W-1:0]   res_man;

  typedef struct packed {
    logic         owner;
    logic [W-1:0] res;
  } exp_t;

  exp_t sb[$];
  int   gq[$];
  int   gc[$];
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [OPW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    return (op == 4'h1) ? a + b : a ^ b;
  endfunction

  // Stand-in ALU: zero-latency when auto, otherwise driven by the sequence
  always_comb begin
    alu_done   = auto_alu ? alu_start : done_man;
    alu_result = auto_alu ? model(alu_op, alu_a, alu_b) : res_man;
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    chk(tag, W'(obs), W'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop(input logic who, input logic [W-1:0] got);
    exp_t e;
    chkb("sb_nonempty", sb.size() != 0, 1'b1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chkb("sb_owner", who, e.owner);
      chk("sb_result", got, e.res);
    end
  endtask

  // Handshakes are sampled mid-cycle; they take effect on the following rising edge
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (req0_valid && req0_ready) begin
        sb.push_back({1'b0, model(req0_op, req0_a, req0_b)});
        gq.push_back(0);
        gc.push_back(cyc);
      end
      if (req1_valid && req1_ready) begin
        sb.push_back({1'b1, model(req1_op, req1_a, req1_b)});
        gq.push_back(1);
        gc.push_back(cyc);
      end
      if (rsp0_valid && rsp0_ready) pop(1'b0, rsp0_result);
      if (rsp1_valid && rsp1_ready) pop(1'b1, rsp1_result);
    end
  end

  initial begin
    int exp_g[4];
    rst = 1'b1; auto_alu = 1'b1; done_man = 1'b0; res_man = '0;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    tick(); tick();

    // Reset values
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_start", alu_start, 1'b0);
    chkb("rst_rsp0_valid", rsp0_valid, 1'b0);
    chkb("rst_rsp1_valid", rsp1_valid, 1'b0);
    chk("rst_alu_op", W'(alu_op), '0);
    chk("rst_alu_a", alu_a, '0);
    chk("rst_rsp0_result", rsp0_result, '0);
    req0_valid = 1'b1; #1;
    chkb("rst_req0_ready", req0_ready, 1'b0);
    req0_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Single op, ALU done in ISSUE
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_op = 4'h1; req0_a = W'(5); req0_b = W'(7); req0_valid = 1'b1; #1;
    chkb("t1_req0_ready", req0_ready, 1'b1);
    chkb("t1_req1_ready", req1_ready, 1'b0);
    tick();
    req0_valid = 1'b0;
    chkb("t1_start", alu_start, 1'b1);
    chkb("t1_busy", busy, 1'b1);
    chk("t1_alu_a", alu_a, W'(5));
    chk("t1_alu_b", alu_b, W'(7));
    chk("t1_alu_op", W'(alu_op), W'(1));
    tick();
    chkb("t1_start_pulse", alu_start, 1'b0);
    chkb("t1_rsp0_valid", rsp0_valid, 1'b1);
    chk("t1_rsp0_result", rsp0_result, W'(12));
    chkb("t1_rsp1_valid", rsp1_valid, 1'b0);
    tick();
    chkb("t1_idle_busy", busy, 1'b0);
    chkb("t1_idle_rsp0", rsp0_valid, 1'b0);

    // Multi-cycle ALU on requester 1
    auto_alu = 1'b0;
    req1_op = 4'h1; req1_a = '1; req1_b = '0; req1_valid = 1'b1;
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1;
    chkb("t2_start", alu_start, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 5) begin done_man = 1'b1; res_man = '1; end
      #1;
      chkb("t2_busy_wait", busy, 1'b1);
      chkb("t2_req0_ready_wait", req0_ready, 1'b0);
      chkb("t2_no_restart", alu_start, 1'b0);
    end
    tick();
    done_man = 1'b0;
    chkb("t2_rsp1_valid", rsp1_valid, 1'b1);
    chk("t2_rsp1_result", rsp1_result, '1);
    chkb("t2_rsp0_valid", rsp0_valid, 1'b0);
    chk("t2_rsp0_retained", rsp0_result, W'(12));
    chkb("t2_busy_resp", busy, 1'b1);
    chkb("t2_req0_ready_resp", req0_ready, 1'b0);
    tick();
    req0_valid = 1'b0;
    auto_alu = 1'b1;
    chkb("t2_idle_busy", busy, 1'b0);
    tick();

    // Contention with both requesters valid continuously
    gq.delete(); gc.delete();
    req0_op = 4'h2; req0_a = W'(128'h1234); req0_b = W'(128'hFF00);
    req1_op = 4'h1; req1_a = W'(128'h1000); req1_b = W'(128'h0234);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 40 && gq.size() < 4; i++) tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chkb("t3_grants_seen", gq.size() >= 4, 1'b1);
`ifdef ALU_ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    if (gq.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk($sformatf("t3_grant%0d", i), W'(gq[i]), W'(exp_g[i]));
      for (int i = 1; i < 4; i++) chk($sformatf("t3_gap%0d", i), W'(gc[i] - gc[i-1]), W'(3));
    end
    tick(); tick(); tick(); tick();

    // Backpressure on requester 0
    rsp0_ready = 1'b0;
    req0_op = 4'h1; req0_a = W'(100); req0_b = W'(23); req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    tick();
    req1_op = 4'h1; req1_a = W'(7); req1_b = W'(8); req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chkb("t4_rsp0_valid", rsp0_valid, 1'b1);
      chk("t4_rsp0_result", rsp0_result, W'(123));
      chkb("t4_req1_ready", req1_ready, 1'b0);
      chkb("t4_busy", busy, 1'b1);
      tick();
    end
    rsp0_ready = 1'b1; #1;
    chkb("t4_rsp0_valid_last", rsp0_valid, 1'b1);
    tick();
    chkb("t4_idle_busy", busy, 1'b0);
    chkb("t4_idle_rsp0", rsp0_valid, 1'b0);
    chkb("t4_idle_req1_ready", req1_ready, 1'b1);
    tick();
    req1_valid = 1'b0;
    tick(); tick();

    // Reset while waiting on the ALU, then a late done
    auto_alu = 1'b0;
    req0_op = 4'h1; req0_a = W'(9); req0_b = W'(9); req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    chkb("t5_start", alu_start, 1'b1);
    tick();
    chkb("t5_wait_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0; done_man = 1'b1; res_man = {16{8'hAB}};
    sb.delete();
    chkb("t5_busy", busy, 1'b0);
    chkb("t5_rsp0_valid", rsp0_valid, 1'b0);
    chkb("t5_rsp1_valid", rsp1_valid, 1'b0);
    chk("t5_alu_a", alu_a, '0);
    chk("t5_alu_op", W'(alu_op), '0);
    chk("t5_rsp0_result", rsp0_result, '0);
    chk("t5_rsp1_result", rsp1_result, '0);
    tick();
    chkb("t5_late_busy", busy, 1'b0);
    chkb("t5_late_rsp0", rsp0_valid, 1'b0);
    chkb("t5_late_rsp1", rsp1_valid, 1'b0);
    done_man = 1'b0; auto_alu = 1'b1;
    req0_op = 4'h1; req0_a = W'(40); req0_b = W'(2);
    req1_op = 4'h1; req1_a = W'(50); req1_b = W'(3);
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    chkb("t5_grant0", req0_ready, 1'b1);
    chkb("t5_nogrant1", req1_ready, 1'b0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); tick(); tick();

    // Spurious alu_done in IDLE
    auto_alu = 1'b0; done_man = 1'b1; res_man = '1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chkb("t6_busy", busy, 1'b0);
      chkb("t6_start", alu_start, 1'b0);
      chkb("t6_rsp0_valid", rsp0_valid, 1'b0);
      chkb("t6_rsp1_valid", rsp1_valid, 1'b0);
    end
    chk("t6_rsp0_result", rsp0_result, W'(42));
    done_man = 1'b0;
    tick();

    chk("sb_drained", W'(sb.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
